// File: rtl/multi_pkg.sv
// Shared state encodings and sizing helper for the shift-add multiplier sequencer.
package multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Step counter width: enough for 0..WIDTH-1, never narrower than one bit.
   function automatic int cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/multi_alu.sv
// Accumulator for the shift-add multiplier; P holds the running/final product.
module multi_alu #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 need_add,
   input  logic                 p_init,
   input  logic [2*WIDTH-1:0]   AS,
   output logic [2*WIDTH-1:0]   P
);

   logic [2*WIDTH-1:0] p_q;

   // First step overwrites P so a previous product never leaks into the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else if (p_init) begin
         p_q <= need_add ? AS : '0;
      end else if (need_add) begin
         p_q <= p_q + AS;
      end
   end

   assign P = p_q;

endmodule

// File: rtl/multi_ctrl.sv
// Sequencer for the shift-add multiplier: one ALU step per multiplier bit, then a held result.
module multi_ctrl #(
   parameter int WIDTH      = 4,
   parameter int EARLY_EXIT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 need_add,
   output logic                 p_init,
   output logic [2*WIDTH-1:0]   AS,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);
   import multi_pkg::*;

   localparam int CNT_W = cnt_w(WIDTH);

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]     b_sh_q, b_sh_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 last_step;

   // The current bit is the last one either by count or, with early exit, because no set bits remain above it.
   assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) ||
                      ((EARLY_EXIT != 0) && ((b_sh_q >> 1) == '0));

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      need_add  = 1'b0;
      p_init    = 1'b0;
      AS        = '0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_sh_d  = {{WIDTH{1'b0}}, a_in};
               b_sh_d  = b_in;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            need_add = b_sh_q[0];
            AS       = a_sh_q;
            p_init   = (cnt_q == '0);
            a_sh_d   = a_sh_q << 1;
            b_sh_d   = b_sh_q >> 1;
            if (last_step) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multi_ctrl.sv
// Bench for multi_ctrl + multi_alu: instance 0 runs all WIDTH steps, instance 1 exits early.
module tb_multi_ctrl;

   localparam int WIDTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv[2], ir[2], na[2], pi[2], ov[2], ordy[2], bsy[2];
   logic [3:0] ai[2], bi[2];
   logic [7:0] as_w[2], p_w[2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(0)) u_ctrl0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a_in(ai[0]), .b_in(bi[0]), .need_add(na[0]), .p_init(pi[0]), .AS(as_w[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bsy[0])
   );
   multi_alu #(.WIDTH(WIDTH)) u_alu0 (
      .clk(clk), .rst_n(rst_n), .need_add(na[0]), .p_init(pi[0]), .AS(as_w[0]), .P(p_w[0])
   );
   multi_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1)) u_ctrl1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a_in(ai[1]), .b_in(bi[1]), .need_add(na[1]), .p_init(pi[1]), .AS(as_w[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bsy[1])
   );
   multi_alu #(.WIDTH(WIDTH)) u_alu1 (
      .clk(clk), .rst_n(rst_n), .need_add(na[1]), .p_init(pi[1]), .AS(as_w[1]), .P(p_w[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   task automatic check_idle(input int u, input logic [7:0] exp_p);
      check("idle_rdy",  32'(ir[u]), 1);
      check("idle_ov",   32'(ov[u]), 0);
      check("idle_na",   32'(na[u]), 0);
      check("idle_pi",   32'(pi[u]), 0);
      check("idle_as",   32'(as_w[u]), 0);
      check("idle_busy", 32'(bsy[u]), 0);
      check("idle_p",    32'(p_w[u]), 32'(exp_p));
   endtask

   // Reference: step i adds A<<i when bit i of B is set; early exit stops after the highest set bit.
   task automatic do_op(input int u, input logic [3:0] a, input logic [3:0] b,
                        input int hold, input bit pulse);
      int         n_run;
      logic [7:0] prod;
      logic [7:0] a8;
      n_run = WIDTH;
      if (u == 1) begin
         n_run = 1;
         for (int i = 0; i < WIDTH; i++) if (b[i]) n_run = i + 1;
      end
      a8   = {4'b0, a};
      prod = a8 * {4'b0, b};

      @(negedge clk);
      check("accept_rdy", 32'(ir[u]), 1);
      ai[u] = a; bi[u] = b; iv[u] = 1'b1; ordy[u] = 1'b0;
      @(negedge clk);
      iv[u] = 1'b0;
      for (int i = 0; i < n_run; i++) begin
         check("run_busy", 32'(bsy[u]), 1);
         check("run_rdy",  32'(ir[u]), 0);
         check("run_ov",   32'(ov[u]), 0);
         check("need_add", 32'(na[u]), 32'(b[i]));
         check("as",       32'(as_w[u]), 32'(a8 << i));
         check("p_init",   32'(pi[u]), (i == 0) ? 1 : 0);
         @(negedge clk);
      end
      check("done_ov",  32'(ov[u]), 1);
      check("product",  32'(p_w[u]), 32'(prod));
      check("done_na",  32'(na[u]), 0);
      check("done_pi",  32'(pi[u]), 0);
      check("done_rdy", 32'(ir[u]), 0);
      for (int h = 0; h < hold; h++) begin
         if (pulse) begin
            iv[u] = ~iv[u]; ai[u] = 4'd1; bi[u] = 4'd1;
         end
         @(negedge clk);
         check("hold_ov",   32'(ov[u]), 1);
         check("hold_p",    32'(p_w[u]), 32'(prod));
         check("hold_rdy",  32'(ir[u]), 0);
      end
      iv[u] = 1'b0; ordy[u] = 1'b1;
      @(negedge clk);
      ordy[u] = 1'b0;
      check_idle(u, prod);
   endtask

   task automatic wait_ov(input int u, input string tag);
      int k;
      k = 0;
      while (!ov[u] && k < 20) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(ov[u]), 1);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         iv[u] = 1'b0; ordy[u] = 1'b0; ai[u] = '0; bi[u] = '0;
      end
      repeat (3) @(negedge clk);
      check_idle(0, 8'd0);
      check_idle(1, 8'd0);
      rst_n = 1'b1;

      // Directed: basic, maximum operand, zero multiplier clears P, back-pressure with ignored pulses.
      do_op(0, 4'd3, 4'd5, 0, 1'b0);
      do_op(0, 4'd15, 4'd15, 3, 1'b1);
      @(negedge clk);
      check("no_second_busy", 32'(bsy[0]), 0);
      do_op(0, 4'd7, 4'd0, 1, 1'b0);

      // Back-to-back with in_valid held high.
      @(negedge clk);
      ai[0] = 4'd2; bi[0] = 4'd3; iv[0] = 1'b1; ordy[0] = 1'b1;
      wait_ov(0, "b2b_ov1");
      check("b2b_p1", 32'(p_w[0]), 6);
      ai[0] = 4'd4; bi[0] = 4'd4;
      @(negedge clk);
      check("b2b_gap_busy", 32'(bsy[0]), 0);
      check("b2b_gap_ov",   32'(ov[0]), 0);
      @(negedge clk);
      iv[0] = 1'b0;
      check("b2b_accept", 32'(bsy[0]), 1);
      check("b2b_pinit",  32'(pi[0]), 1);
      wait_ov(0, "b2b_ov2");
      check("b2b_p2", 32'(p_w[0]), 16);
      @(negedge clk);
      ordy[0] = 1'b0;
      check_idle(0, 8'd16);

      // Reset in the second RUN cycle aborts everything.
      @(negedge clk);
      ai[0] = 4'd9; bi[0] = 4'd9; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      @(negedge clk);
      check("rst_run2_busy", 32'(bsy[0]), 1);
      rst_n = 1'b0;
      #1;
      check_idle(0, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 4'd9, 4'd9, 0, 1'b0);

      // Early-exit instance.
      do_op(1, 4'd5, 4'd1, 0, 1'b0);
      do_op(1, 4'd5, 4'd8, 0, 1'b0);
      do_op(1, 4'd7, 4'd0, 0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         do_op(1, 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end
      for (int n = 0; n < 200; n++) begin
         do_op(0, 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
